// File: rtl/multi_edge_pulser.sv
// Per-channel synchroniser, debounce filter, edge selection and hold-to-repeat
// pulse generation for dance-pad inputs; every pulse is one clk cycle wide.
module multi_edge_pulser #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [1:0]   mode,
    input  logic         repeat_en,
    output logic [N-1:0] level,
    output logic [N-1:0] pulse,
    output logic         any_pulse
);

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DLAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RDLAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPLAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HELD_DELAY  = 2'd1,
        HELD_REPEAT = 2'd2
    } rep_state_e;

    logic [N-1:0]   s1_q, s2_q;
    logic [N-1:0]   level_q, level_d;
    logic [N-1:0]   pulse_q, pulse_d;
    logic [DW-1:0]  dcnt_q [N];
    logic [DW-1:0]  dcnt_d [N];
    logic [RW-1:0]  rcnt_q [N];
    logic [RW-1:0]  rcnt_d [N];
    rep_state_e     state_q [N];
    rep_state_e     state_d [N];

    logic [N-1:0]   rise_w, fall_w, rep_fire_w;
    logic           rise_ok, fall_ok, rep_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < N; i++) begin
                dcnt_q[i]  <= '0;
                rcnt_q[i]  <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            s1_q    <= a;
            s2_q    <= s1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < N; i++) begin
                dcnt_q[i]  <= dcnt_d[i];
                rcnt_q[i]  <= rcnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        rise_ok    = (mode == 2'b00) || (mode == 2'b10);
        fall_ok    = (mode == 2'b01) || (mode == 2'b10);
        rep_ok     = repeat_en && rise_ok;
        level_d    = level_q;
        pulse_d    = '0;
        rise_w     = '0;
        fall_w     = '0;
        rep_fire_w = '0;
        for (int i = 0; i < N; i++) begin
            dcnt_d[i]  = '0;
            rcnt_d[i]  = rcnt_q[i];
            state_d[i] = state_q[i];

            if (s2_q[i] != level_q[i]) begin
                if (dcnt_q[i] == DLAST) begin
                    level_d[i] = s2_q[i];
                    rise_w[i]  = s2_q[i];
                    fall_w[i]  = ~s2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end

            // Level flips take priority; a disabled repeat parks the channel
            // at the start of the delay so re-enabling waits the full delay.
            if (fall_w[i]) begin
                state_d[i] = IDLE;
                rcnt_d[i]  = '0;
            end else if (rise_w[i] || (state_q[i] != IDLE && !rep_ok)) begin
                state_d[i] = HELD_DELAY;
                rcnt_d[i]  = '0;
            end else begin
                case (state_q[i])
                    HELD_DELAY: begin
                        if (rcnt_q[i] == RDLAST) begin
                            rep_fire_w[i] = 1'b1;
                            state_d[i]    = HELD_REPEAT;
                            rcnt_d[i]     = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                    HELD_REPEAT: begin
                        if (rcnt_q[i] == RPLAST) begin
                            rep_fire_w[i] = 1'b1;
                            rcnt_d[i]     = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        rcnt_d[i]  = '0;
                    end
                endcase
            end

            pulse_d[i] = (rise_w[i] & rise_ok) | (fall_w[i] & fall_ok) | rep_fire_w[i];
        end
    end

    assign level     = level_q;
    assign pulse     = pulse_q;
    assign any_pulse = |pulse_q;

endmodule

// File: tb/tb_multi_edge_pulser.sv
// Directed bench for multi_edge_pulser: debounce latency, glitch rejection,
// edge modes, hold-to-repeat timing and asynchronous reset behaviour.
module tb_multi_edge_pulser;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a;
    logic [1:0] mode;
    logic       repeat_en;
    logic [3:0] level;
    logic [3:0] pulse;
    logic       any_pulse;

    int n_assert = 0;
    int n_fail   = 0;

    multi_edge_pulser #(
        .N(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .reset(reset), .a(a), .mode(mode), .repeat_en(repeat_en),
        .level(level), .pulse(pulse), .any_pulse(any_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int e, input logic [3:0] obs, input logic [3:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s e=%0d: observed %b expected %b", tag, e, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int e, input logic [3:0] exp_p, input logic [3:0] exp_l);
        chk({tag, "_pulse"}, e, pulse, exp_p);
        chk({tag, "_level"}, e, level, exp_l);
        chk({tag, "_any"}, e, {3'b000, any_pulse}, {3'b000, |exp_p});
    endtask

    initial begin
        reset = 1'b0; a = '0; mode = 2'b00; repeat_en = 1'b0;
        #1;
        chk_all("reset", -1, 4'b0000, 4'b0000);
        tick(); tick();
        reset = 1'b1;

        // Single press on ch0, rise mode: pulse only at edge 5; release is silent.
        a[0] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk_all("t1_press", e, (e == 5) ? 4'b0001 : 4'b0000, (e >= 5) ? 4'b0001 : 4'b0000);
        end
        a[0] = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk_all("t1_release", e, 4'b0000, (e < 5) ? 4'b0001 : 4'b0000);
        end

        // Three-cycle glitch on ch1 is rejected.
        a[1] = 1'b1;
        for (int e = 0; e < 13; e++) begin
            if (e == 3) a[1] = 1'b0;
            tick();
            chk_all("t2_glitch", e, 4'b0000, 4'b0000);
        end

        // Both-edge mode on ch2: rise at 5, fall at 25 after release before edge 20.
        mode = 2'b10;
        a[2] = 1'b1;
        for (int e = 0; e < 35; e++) begin
            if (e == 20) a[2] = 1'b0;
            tick();
            chk_all("t3_both", e, (e == 5 || e == 25) ? 4'b0100 : 4'b0000,
                    (e >= 5 && e < 25) ? 4'b0100 : 4'b0000);
        end

        // Hold-to-repeat on ch0: release before edge 23, level falls at 28.
        mode = 2'b00;
        repeat_en = 1'b1;
        a[0] = 1'b1;
        for (int e = 0; e < 40; e++) begin
            if (e == 23) a[0] = 1'b0;
            tick();
            chk_all("t4_repeat", e, (e inside {5, 13, 16, 19, 22, 25}) ? 4'b0001 : 4'b0000,
                    (e >= 5 && e < 28) ? 4'b0001 : 4'b0000);
        end

        // Drop repeat_en at 14, re-enable at 20 (full delay restarts), release before 29.
        a[0] = 1'b1;
        for (int e = 0; e < 45; e++) begin
            if (e == 14) repeat_en = 1'b0;
            if (e == 20) repeat_en = 1'b1;
            if (e == 29) a[0] = 1'b0;
            tick();
            chk_all("t4_reen", e, (e inside {5, 13, 27, 30, 33}) ? 4'b0001 : 4'b0000,
                    (e >= 5 && e < 34) ? 4'b0001 : 4'b0000);
        end
        repeat_en = 1'b0;

        // All channels together, then disabled mode, then fall-only mode.
        a = 4'b1111;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk_all("t6_rise_all", e, (e == 5) ? 4'b1111 : 4'b0000, (e >= 5) ? 4'b1111 : 4'b0000);
        end
        mode = 2'b11;
        a = 4'b0000;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk_all("t6_dis_fall", e, 4'b0000, (e < 5) ? 4'b1111 : 4'b0000);
        end
        a = 4'b1111;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk_all("t6_dis_rise", e, 4'b0000, (e >= 5) ? 4'b1111 : 4'b0000);
        end
        mode = 2'b01;
        a = 4'b0000;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk_all("t6_fall_all", e, (e == 5) ? 4'b1111 : 4'b0000, (e < 5) ? 4'b1111 : 4'b0000);
        end

        // ch3 held high through reset; release right after edge 0 -> rise at edge 6.
        mode = 2'b00;
        a = 4'b1000;
        reset = 1'b0;
        #1;
        chk_all("t5_in_reset", -1, 4'b0000, 4'b0000);
        tick();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int e = 1; e < 13; e++) begin
            tick();
            chk_all("t5_held_rst", e, (e == 6) ? 4'b1000 : 4'b0000, (e >= 6) ? 4'b1000 : 4'b0000);
        end

        // Reset mid-hold clears outputs immediately, without a clock edge.
        #1;
        reset = 1'b0;
        #1;
        chk_all("t5_async_clr", 0, 4'b0000, 4'b0000);
        for (int e = 0; e < 4; e++) begin
            tick();
            chk_all("t5_rst_hold", e, 4'b0000, 4'b0000);
        end
        a = 4'b0000;
        reset = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk_all("t5_post_rst", e, 4'b0000, 4'b0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
